// File: rtl/sm_shift_add_multiplier_pkg.sv
// Shared definitions for the sign-magnitude multiply/divide blocks:
// default width, FSM encoding and operand field helpers.
package sm_shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_W         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operands are zero-extended to MAX_W+1 bits by the caller; w is the magnitude width.
  function automatic logic sm_sign(input logic [MAX_W:0] op, input int w);
    return |(op & ((MAX_W+1)'(1) << w));
  endfunction

  function automatic logic [MAX_W-1:0] sm_mag(input logic [MAX_W:0] op, input int w);
    logic [MAX_W:0] mask;
    mask = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    return op[MAX_W-1:0] & mask[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sm_mul_datapath.sv
// Magnitude datapath of the shift-add multiplier: M, ACC (with carry) and MQ,
// one conditional add plus a right shift of {ACC,MQ} per step.
module sm_mul_datapath
  import sm_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic [2*WIDTH-1:0]   prod_nxt
);

  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] mq_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] mq_nxt;

  // The adder carry lands in sum[WIDTH] and is shifted down into the ACC MSB.
  always_comb begin
    sum      = acc_r + (mq_r[0] ? {1'b0, m_r} : '0);
    acc_nxt  = {1'b0, sum[WIDTH:1]};
    mq_nxt   = {sum[0], mq_r[WIDTH-1:1]};
    prod_nxt = {acc_nxt[WIDTH-1:0], mq_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r   <= '0;
      mq_r  <= '0;
      acc_r <= '0;
    end else if (load) begin
      m_r   <= mag_a;
      mq_r  <= mag_b;
      acc_r <= '0;
    end else if (step) begin
      acc_r <= acc_nxt;
      mq_r  <= mq_nxt;
    end
  end

endmodule

// File: rtl/sm_shift_add_multiplier.sv
// Sequential sign-magnitude multiplier, one multiplier bit per cycle,
// with a start/busy/done handshake.
module sm_shift_add_multiplier
  import sm_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH:0]     multiplicand,
  input  logic [WIDTH:0]     multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 sign_r;
  logic                 load;
  logic                 step;
  logic                 last;
  logic [MAX_W:0]       mcand_ext;
  logic [MAX_W:0]       mplier_ext;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 sign_in;
  logic [2*WIDTH-1:0]   prod_nxt;

  assign mcand_ext  = (MAX_W+1)'(multiplicand);
  assign mplier_ext = (MAX_W+1)'(multiplier);
  assign mag_a      = WIDTH'(sm_mag(mcand_ext, WIDTH));
  assign mag_b      = WIDTH'(sm_mag(mplier_ext, WIDTH));
  assign sign_in    = sm_sign(mcand_ext, WIDTH) ^ sm_sign(mplier_ext, WIDTH);
  assign last       = step && (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
    load = (state == IDLE) && start;
    step = (state == CALC);
  end

  // A zero magnitude never carries a negative sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sign_r  <= 1'b0;
      product <= '0;
    end else if (load) begin
      cnt    <= '0;
      sign_r <= sign_in;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (last) product <= {sign_r & (|prod_nxt), prod_nxt};
    end
  end

  sm_mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .prod_nxt (prod_nxt)
  );

endmodule

// File: tb/tb_sm_shift_add_multiplier.sv
// Self-checking bench for sm_shift_add_multiplier: directed and random
// operands against a plain-arithmetic reference with per-cycle comparison.
module tb_sm_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [W:0]     mc = '0;
  logic [W:0]     mp = '0;
  logic           busy;
  logic           done;
  logic [2*W:0]   product;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sm_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  function automatic logic [2*W:0] ref_mul(input logic [W:0] a, input logic [W:0] b);
    logic [2*W-1:0] mag;
    mag = (2*W)'(a[W-1:0]) * (2*W)'(b[W-1:0]);
    return {(a[W] ^ b[W]) && (mag != '0), mag};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: result appears WIDTH edges after the load edge, done lasts one cycle.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [2*W:0] m_exp   = '0;
  logic [2*W:0] m_prod  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_exp   <= '0;
      m_prod  <= '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_left  <= W;
          m_exp   <= ref_mul(mc, mp);
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_prod  <= m_exp;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 64'(busy), 64'(m_phase == 1));
    check("cyc_done", 64'(done), 64'(m_phase == 2));
    check("cyc_product", 64'(product), 64'(m_prod));
    check("cyc_busy_done_excl", 64'(busy & done), 64'(0));
  end

  task automatic run_op(input logic [W:0] a, input logic [W:0] b,
                        input logic [2*W:0] exp, input string name);
    int n;
    @(negedge clk);
    mc    = a;
    mp    = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < W + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(W));
    check({name, "_product"}, 64'(product), 64'(exp));
    @(posedge clk);
  endtask

  initial begin
    logic [W:0]   ra;
    logic [W:0]   rb;
    logic [2*W:0] hold_exp;
    int           pulses;

    check("pin_model_176x21", 64'(ref_mul(9'h0B0, 9'h015)), 64'(17'h00E70));
    check("pin_model_m13x5", 64'(ref_mul(9'h10D, 9'h005)), 64'(17'h10041));
    check("pin_model_negzero", 64'(ref_mul(9'h100, 9'h103)), 64'(17'h00000));

    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_product", 64'(product), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op(9'h0B0, 9'h015, 17'h00E70, "dir_176x21");
    run_op(9'h10D, 9'h005, 17'h10041, "dir_m13xp5");
    run_op(9'h10D, 9'h105, 17'h00041, "dir_m13xm5");
    run_op(9'h0FF, 9'h1FF, 17'h1FE01, "dir_carry");
    run_op(9'h100, 9'h103, 17'h00000, "dir_negzero");
    run_op(9'h000, 9'h000, 17'h00000, "dir_zero");

    for (int i = 0; i < 40; i++) begin
      ra = (W+1)'($urandom);
      rb = (W+1)'($urandom);
      case ($urandom_range(0, 4))
        0: ra[W-1:0] = '0;
        1: rb[W-1:0] = '1;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, ref_mul(ra, rb), "rand");
    end

    // start held through CALC while operands change after the load edge
    @(negedge clk);
    mc    = 9'h0B0;
    mp    = 9'h015;
    start = 1'b1;
    hold_exp = 17'h00E70;
    @(posedge clk);
    @(negedge clk);
    mc = (W+1)'($urandom);
    mp = (W+1)'($urandom);
    pulses = 0;
    for (int k = 0; k < W + 6; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        start = 1'b0;
        check("hold_product_at_done", 64'(product), 64'(hold_exp));
      end
    end
    check("hold_single_done", 64'(pulses), 64'(1));
    check("hold_product_kept", 64'(product), 64'(hold_exp));

    // asynchronous abort in the middle of CALC
    @(negedge clk);
    mc    = 9'h0FF;
    mp    = 9'h0FF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_product", 64'(product), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'(0));
    run_op(9'h003, 9'h007, 17'h00015, "post_reset_3x7");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
